dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 26 ++
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
//   state_t   : responder FSM states
//   WORD_W    : data word width
//   LAT_CNT_W : width of the latency down-counter
//   addr_err  : flags misaligned or out-of-range byte addresses
package dmem_responder_pkg;

  localparam int WORD_W    = 32;
  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // The limit is computed two bits wider than the address so that large
  // DEPTH_WORDS values cannot overflow the byte-size product.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                    input int depth_words);
    logic [WORD_W+1:0] limit;
    limit = (WORD_W+2)'(depth_words) << 2;
    return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage for the data-memory responder. No reset.
//   clk_i : clock
//   we    : write enable, writes wdata to mem[addr] at the clock edge
//   re    : read enable, loads mem[addr] into rdata at the clock edge
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, holds until the next read
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the MEM-stage data-memory interface. Accepts one load or
// store, holds the pipeline with stall_o for 1+LATENCY cycles, then returns
// a one-cycle ack (with err on a bad request) and the load data.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   addr_i, wdata_i      : byte address and store data
//   MemRead_i/MemWrite_i : level-sensitive load/store request
//   stall_o              : pipeline freeze
//   ack_o, err_o         : one-cycle completion and error pulses
//   rdata_o              : load result
//   access_cnt_o         : completed-access counter (wraps)
//
// state | meaning
// IDLE  | waiting for a request; stall follows the request combinationally
// WAIT  | latency down-count on the latched request; access at terminal count
// RESP  | ack (and err) pulse; pipeline advances at the end of this cycle
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  output logic              stall_o,
  output logic              ack_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              err_o,
  output logic [15:0]       access_cnt_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [LAT_CNT_W-1:0] CNT_LOAD = LAT_CNT_W'(LATENCY - 1);

  state_t               state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0]    addr_q, wdata_q, arr_rdata;
  logic                 rd_q, wr_q, err_q;
  logic                 rzero_q;
  logic                 latch, mem_we, mem_re, req_err, at_tc;

  assign req_err = addr_err(addr_q, DEPTH_WORDS) | (rd_q & wr_q);
  assign at_tc   = (state_q == WAIT) && (cnt_q == '0);
  assign ack_o   = (state_q == RESP);
  assign err_o   = ack_o & err_q;
  // The array output register cannot be reset, so a flag selects zero after
  // reset or an errored access until the next good load refreshes it.
  assign rdata_o = rzero_q ? '0 : arr_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    stall_o = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemRead_i | MemWrite_i) begin
          stall_o = 1'b1;
          latch   = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          mem_we  = wr_q & ~req_err;
          mem_re  = rd_q & ~req_err;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Reset drops the stall in the sampling cycle and kills a pending write.
    if (rst_i) begin
      stall_o = 1'b0;
      mem_we  = 1'b0;
      mem_re  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
      rzero_q      <= 1'b1;
      access_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        rd_q    <= MemRead_i;
        wr_q    <= MemWrite_i;
      end
      if (at_tc) begin
        err_q <= req_err;
        if (req_err)   rzero_q <= 1'b1;
        else if (rd_q) rzero_q <= 1'b0;
      end
      if (state_q == RESP) access_cnt_o <= access_cnt_o + 16'd1;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk_i(clk_i),
    .we   (mem_we),
    .re   (mem_re),
    .addr (addr_q[AW+1:2]),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic        rd, wr, stall, ack, err;
  logic [15:0] acnt;
  logic [31:0] addr1, wdata1, rdata1;
  logic        rd1, wr1, stall1, ack1, err1;
  logic [15:0] acnt1;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .wdata_i(wdata),
    .MemRead_i(rd), .MemWrite_i(wr), .stall_o(stall), .ack_o(ack),
    .rdata_o(rdata), .err_o(err), .access_cnt_o(acnt)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr1), .wdata_i(wdata1),
    .MemRead_i(rd1), .MemWrite_i(wr1), .stall_o(stall1), .ack_o(ack1),
    .rdata_o(rdata1), .err_o(err1), .access_cnt_o(acnt1)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [15:0] cnt;
  } sb_t;

  vec_t        vecs[12];
  sb_t         sbq[$];
  logic [15:0] exp_cnt = '0;
  int          total = 0;
  int          passed = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Scoreboard: every ack of the LATENCY=4 instance pops one expectation.
  always @(negedge clk) begin : monitor
    sb_t e;
    if (ack === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL unexpected_ack: got ack with empty scoreboard, expected none");
      end else begin
        e = sbq.pop_front();
        chk("sb_err", 32'(err), 32'(e.err));
        chk("sb_rdata", rdata, e.rdata);
        chk("sb_access_cnt", 32'(acnt), 32'(e.cnt));
      end
    end
  end

  task automatic do_req(input vec_t v);
    int n_stall;
    bit got;
    @(negedge clk);
    rd = v.rd; wr = v.wr; addr = v.addr; wdata = v.wdata;
    sbq.push_back('{v.err, v.rdata, exp_cnt});
    exp_cnt++;
    n_stall = 0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      #1;
      if (ack) got = 1'b1;
      else begin
        if (stall) n_stall++;
        @(negedge clk);
      end
    end
    rd = 1'b0; wr = 1'b0;
    chk("ack_seen", 32'(got), 32'd1);
    chk("stall_cycles", 32'(n_stall), 32'd5);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit got;
    int n_ack;
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0000_0000};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 1'b1, 32'h0000_0000};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0000, 32'hBAD0_BAD0, 1'b1, 32'h0000_0000};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 1'b0, 32'h1234_5678};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'hA5A5_A5A5};
    vecs[11] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000};

    rst = 1'b1;
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_access_cnt", 32'(acnt), 32'd0);

    for (int i = 0; i < 12; i++) do_req(vecs[i]);
    @(negedge clk); #1;
    chk("cnt_after_table", 32'(acnt), 32'd12);

    // Reset during WAIT of a store: old value must survive.
    do_req('{1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0, 32'h0000_0000});
    @(negedge clk);
    wr = 1'b1; addr = 32'h20; wdata = 32'h2222_2222;
    #1 chk("abort_accept_stall", 32'(stall), 32'd1);
    @(negedge clk);
    wr = 1'b0;
    #1 chk("abort_wait_stall", 32'(stall), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("stall_drops_in_reset", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    #1;
    chk("abort_idle_stall", 32'(stall), 32'd0);
    chk("abort_idle_ack", 32'(ack), 32'd0);
    chk("abort_cnt_cleared", 32'(acnt), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      chk("no_ack_after_abort", 32'(ack), 32'd0);
    end
    do_req('{1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h1111_1111});

    // LATENCY=1 instance: one store, then ten loads with MemRead held high.
    @(negedge clk);
    wr1 = 1'b1; addr1 = 32'h10; wdata1 = 32'h0BAD_F00D;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (ack1) got = 1'b1;
      else @(negedge clk);
    end
    wr1 = 1'b0;
    chk("lat1_store_ack", 32'(got), 32'd1);
    @(negedge clk);
    rd1 = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      chk("b2b_stall", 32'(stall1), 32'((i % 3) != 2));
      chk("b2b_ack", 32'(ack1), 32'((i % 3) == 2));
      if (ack1) begin
        n_ack++;
        chk("b2b_rdata", rdata1, 32'h0BAD_F00D);
        chk("b2b_err", 32'(err1), 32'd0);
      end
      if (i == 29) rd1 = 1'b0;
      @(negedge clk);
    end
    #1;
    chk("b2b_ack_count", 32'(n_ack), 32'd10);
    chk("b2b_access_cnt", 32'(acnt1), 32'd11);
    chk("b2b_idle_ack", 32'(ack1), 32'd0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
